// File: rtl/mdio_apb_pkg.sv
// Shared definitions for the MDIO-side APB fan-out fabric.
package mdio_apb_pkg;

  localparam int unsigned APB_AW = 21;
  localparam int unsigned APB_DW = 16;

  localparam logic [APB_DW-1:0] ERR_DATA_DFLT = 16'hDEAD;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int unsigned idx_width(input int unsigned nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/mdio_apb_wdog.sv
// Access-phase watchdog plus a saturating count of expired accesses.
module mdio_apb_wdog
  import mdio_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_100m,
  input  logic       rstn_100m,
  input  logic       i_clear,
  input  logic       i_run,
  input  logic       i_ready,
  output logic       o_expire,
  output logic [7:0] o_timeout_cnt
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tcnt;
  logic          w_hit;

  // Fires on the TIMEOUT-th access cycle so the select drops right after it.
  assign w_hit         = (TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT);
  assign o_expire      = i_run & w_hit & ~i_ready;
  assign o_timeout_cnt = r_tcnt;

  always_ff @(posedge clk_100m or negedge rstn_100m) begin
    if (!rstn_100m) begin
      r_cnt  <= '0;
      r_tcnt <= '0;
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_run && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (o_expire && (r_tcnt != 8'hFF)) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mdio_apb_fabric.sv
// Registered APB3 fan-out from the MDIO request port to NSLV register-bank slaves.
module mdio_apb_fabric
  import mdio_apb_pkg::*;
#(
  parameter int unsigned       NSLV     = 4,
  parameter int unsigned       SEL_LSB  = 19,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [APB_DW-1:0] ERR_DATA = ERR_DATA_DFLT
) (
  input  logic                   clk_100m,
  input  logic                   rstn_100m,
  input  logic [APB_AW-1:0]      m_paddr,
  input  logic                   m_pwrite,
  input  logic                   m_psel,
  input  logic                   m_penable,
  input  logic [APB_DW-1:0]      m_pwdata,
  output logic                   m_pready,
  output logic                   m_pslverr,
  output logic [APB_DW-1:0]      m_prdata,
  output logic [APB_AW-1:0]      s_paddr,
  output logic                   s_pwrite,
  output logic                   s_penable,
  output logic [APB_DW-1:0]      s_pwdata,
  output logic [NSLV-1:0]        s_psel,
  input  logic [NSLV-1:0]        s_pready,
  input  logic [NSLV-1:0]        s_pslverr,
  input  logic [APB_DW*NSLV-1:0] s_prdata,
  input  logic [NSLV-1:0]        slv_enable,
  output logic                   err_timeout,
  output logic                   err_unmapped,
  output logic [7:0]             timeout_cnt
);

  localparam int unsigned IW = idx_width(NSLV);

  state_t            r_state;
  logic [APB_AW-1:0] r_addr;
  logic              r_write;
  logic [APB_DW-1:0] r_wdata;
  logic [IW-1:0]     r_idx;
  logic [APB_DW-1:0] r_rdata;
  logic              r_slverr;
  logic              r_abort;
  logic              r_err_to;
  logic              r_err_um;

  state_t            w_state_d;
  logic [IW-1:0]     w_idx;
  logic              w_setup;
  logic              w_slv_en;
  logic              w_active;
  logic              w_sel_ready;
  logic              w_sel_err;
  logic [APB_DW-1:0] w_sel_rdata;
  logic              w_expire;
  logic              w_abort;

  assign w_idx    = m_paddr[SEL_LSB +: IW];
  assign w_setup  = m_psel & ~m_penable;
  assign w_slv_en = slv_enable[w_idx];
  assign w_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  // A master that walked away still lets the slave finish, but gets no response.
  assign w_abort  = r_abort | ~m_psel;

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    s_psel      = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_ready = s_pready[i];
        w_sel_err   = s_pslverr[i];
        w_sel_rdata = s_prdata[APB_DW*i +: APB_DW];
        s_psel[i]   = w_active;
      end
    end
  end

  mdio_apb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_100m      (clk_100m),
    .rstn_100m     (rstn_100m),
    .i_clear       ((r_state == ST_IDLE) && w_setup && w_slv_en),
    .i_run         (r_state == ST_ACCESS),
    .i_ready       (w_sel_ready),
    .o_expire      (w_expire),
    .o_timeout_cnt (timeout_cnt)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:   if (w_setup) w_state_d = w_slv_en ? ST_SETUP : ST_DONE;
      ST_SETUP:  w_state_d = ST_ACCESS;
      ST_ACCESS: if (w_sel_ready || w_expire) w_state_d = w_abort ? ST_IDLE : ST_DONE;
      default:   w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rstn_100m) begin
    if (!rstn_100m) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_abort  <= 1'b0;
      r_err_to <= 1'b0;
      r_err_um <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_err_to <= 1'b0;
      r_err_um <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_addr   <= m_paddr;
            r_write  <= m_pwrite;
            r_wdata  <= m_pwdata;
            r_idx    <= w_idx;
            r_abort  <= 1'b0;
            r_slverr <= 1'b0;
            if (!w_slv_en) begin
              r_slverr <= 1'b1;
              r_rdata  <= m_pwrite ? '0 : ERR_DATA;
              r_err_um <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (!m_psel) r_abort <= 1'b1;
        end
        ST_ACCESS: begin
          if (!m_psel) r_abort <= 1'b1;
          if (w_sel_ready) begin
            r_rdata  <= r_write ? '0 : w_sel_rdata;
            r_slverr <= w_sel_err;
          end else if (w_expire) begin
            r_rdata  <= ERR_DATA;
            r_slverr <= 1'b1;
            r_err_to <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_pready     = (r_state == ST_DONE);
  assign m_prdata     = m_pready ? r_rdata : '0;
  assign m_pslverr    = m_pready & r_slverr;
  assign s_paddr      = r_addr;
  assign s_pwrite     = r_write;
  assign s_pwdata     = r_wdata;
  assign s_penable    = (r_state == ST_ACCESS);
  assign err_timeout  = r_err_to;
  assign err_unmapped = r_err_um;

endmodule

// File: tb/tb_mdio_apb_fabric.sv
// Scoreboard bench for mdio_apb_fabric: directed cases then randomized traffic.
module tb_mdio_apb_fabric;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [20:0] m_paddr;
  logic        m_pwrite, m_psel, m_penable;
  logic [15:0] m_pwdata;
  logic        m_pready, m_pslverr;
  logic [15:0] m_prdata;
  logic [20:0] s_paddr;
  logic        s_pwrite, s_penable;
  logic [15:0] s_pwdata;
  logic [3:0]  s_psel, s_pready, s_pslverr, slv_enable;
  logic [63:0] s_prdata;
  logic        err_timeout, err_unmapped;
  logic [7:0]  timeout_cnt;

  mdio_apb_fabric #(
    .NSLV     (4),
    .SEL_LSB  (19),
    .TIMEOUT  (TO),
    .ERR_DATA (16'hDEAD)
  ) dut (
    .clk_100m     (clk),
    .rstn_100m    (rstn),
    .m_paddr      (m_paddr),
    .m_pwrite     (m_pwrite),
    .m_psel       (m_psel),
    .m_penable    (m_penable),
    .m_pwdata     (m_pwdata),
    .m_pready     (m_pready),
    .m_pslverr    (m_pslverr),
    .m_prdata     (m_prdata),
    .s_paddr      (s_paddr),
    .s_pwrite     (s_pwrite),
    .s_penable    (s_penable),
    .s_pwdata     (s_pwdata),
    .s_psel       (s_psel),
    .s_pready     (s_pready),
    .s_pslverr    (s_pslverr),
    .s_prdata     (s_prdata),
    .slv_enable   (slv_enable),
    .err_timeout  (err_timeout),
    .err_unmapped (err_unmapped),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        slverr;
    int          lat;
    int          t0;
    logic        to;
    logic        um;
    logic [7:0]  tcnt;
  } mexp_t;

  typedef struct {
    logic [20:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [3:0]  sel;
  } sexp_t;

  mexp_t mq[$];
  sexp_t sq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, pready_cnt = 0, cfg_wait = 0, model_tcnt = 0, acc_k = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: response and latency follow from the slave's mapping and wait count alone.
  function automatic mexp_t predict(input logic [20:0] a, input logic wr, input int wt);
    mexp_t e;
    int    idx;
    idx  = int'(a[20:19]);
    e.to = 1'b0;
    e.um = 1'b0;
    e.t0 = 0;
    if (!slv_enable[idx]) begin
      e.um = 1'b1; e.slverr = 1'b1; e.rdata = wr ? 16'h0 : 16'hDEAD; e.lat = 1;
    end else if (wt >= TO) begin
      e.to = 1'b1; e.slverr = 1'b1; e.rdata = 16'hDEAD; e.lat = 2 + TO;
      if (model_tcnt < 255) model_tcnt++;
    end else begin
      e.slverr = s_pslverr[idx];
      e.rdata  = wr ? 16'h0 : s_prdata[16*idx +: 16];
      e.lat    = 3 + wt;
    end
    e.tcnt = 8'(model_tcnt);
    return e;
  endfunction

  task automatic xfer(input logic [20:0] a, input logic wr, input logic [15:0] wd,
                      input int wt, input bit abort);
    mexp_t e;
    sexp_t s;
    int    idx, k, pc0;
    idx  = int'(a[20:19]);
    e    = predict(a, wr, wt);
    e.t0 = cyc;
    if (!abort) mq.push_back(e);
    if (slv_enable[idx] && wt < TO) begin
      s.addr = a; s.wr = wr; s.wdata = wd; s.sel = 4'b0001 << idx;
      sq.push_back(s);
    end
    cfg_wait = wt;
    m_paddr = a; m_pwrite = wr; m_pwdata = wd; m_psel = 1'b1; m_penable = 1'b0;
    pc0 = pready_cnt;
    @(posedge clk); #1;
    check("setup_psel", 32'(s_psel), slv_enable[idx] ? 32'(4'b0001 << idx) : 32'h0);
    check("setup_penable", 32'(s_penable), 32'h0);
    m_penable = 1'b1;
    if (abort) begin
      @(posedge clk); @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_pready", 32'(pready_cnt - pc0), 32'h0);
      return;
    end
    k = 0;
    while (!m_pready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("pready_seen", 32'(m_pready), 32'h1);
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge clk); #1;
    check("post_done_pready", 32'(m_pready), 32'h0);
    check("post_done_prdata", 32'(m_prdata), 32'h0);
  endtask

  task automatic reset_zero(input string tag);
    check({tag, "_ctl"}, 32'({m_pready, m_pslverr, m_prdata, s_psel, s_penable, s_pwrite,
                              err_timeout, err_unmapped}), 32'h0);
    check({tag, "_paddr"}, 32'(s_paddr), 32'h0);
    check({tag, "_pwdata"}, 32'(s_pwdata), 32'h0);
    check({tag, "_tcnt"}, 32'(timeout_cnt), 32'h0);
  endtask

  // Master-side monitor.
  always @(negedge clk) begin
    mexp_t e;
    if (rstn) begin
      if (m_pready) begin
        pready_cnt++;
        if (mq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pready: got m_pready=1, required no response");
        end else begin
          e = mq.pop_front();
          check("m_prdata", 32'(m_prdata), 32'(e.rdata));
          check("m_pslverr", 32'(m_pslverr), 32'(e.slverr));
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
          check("err_timeout", 32'(err_timeout), 32'(e.to));
          check("err_unmapped", 32'(err_unmapped), 32'(e.um));
          check("timeout_cnt", 32'(timeout_cnt), 32'(e.tcnt));
          check("done_psel", 32'({s_psel, s_penable}), 32'h0);
        end
      end else begin
        check("idle_resp", 32'({m_pslverr, m_prdata}), 32'h0);
      end
    end
  end

  // Slave responder and slave-side monitor.
  always @(negedge clk) begin
    sexp_t s;
    if (s_penable && (s_psel != 4'b0)) acc_k++;
    else acc_k = 0;
    s_pready = (acc_k > cfg_wait) ? s_psel : 4'b0;
    if (s_penable && ((s_psel & s_pready) != 4'b0)) begin
      if (sq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_slave_xfer: got s_psel=0x%0h, required none", s_psel);
      end else begin
        s = sq.pop_front();
        check("s_psel", 32'(s_psel), 32'(s.sel));
        check("s_paddr", 32'(s_paddr), 32'(s.addr));
        check("s_pwrite", 32'(s_pwrite), 32'(s.wr));
        check("s_pwdata", 32'(s_pwdata), 32'(s.wdata));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    m_paddr = '0; m_pwrite = 1'b0; m_psel = 1'b0; m_penable = 1'b0; m_pwdata = '0;
    s_pready = '0; s_pslverr = '0; s_prdata = '0; slv_enable = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    reset_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    xfer(21'h080010, 1'b1, 16'h1234, 0, 1'b0);

    s_prdata = {$urandom, $urandom};
    s_prdata[47:32] = 16'hBEEF;
    s_pslverr = 4'b0;
    xfer(21'h100000 | 21'($urandom_range(0, 255)), 1'b0, 16'h0, 3, 1'b0);

    slv_enable = 4'b0111;
    xfer(21'h180000, 1'b0, 16'h0, 0, 1'b0);
    slv_enable = 4'hF;

    for (int i = 0; i < 301; i++) xfer(21'($urandom_range(0, 1023)), 1'b0, 16'h0, 1000, 1'b0);
    check("tcnt_saturated", 32'(timeout_cnt), 32'hFF);

    s_prdata = {$urandom, $urandom};
    xfer(21'h080020, 1'b0, 16'h0, 2, 1'b1);
    xfer(21'h080024, 1'b0, 16'h0, 0, 1'b0);

    // Reset in the middle of an access to a never-ready slave 0.
    cfg_wait = 1000;
    m_paddr = 21'h000040; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1;
    m_penable = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    reset_zero("mid_reset");
    m_psel = 1'b0; m_penable = 1'b0; model_tcnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    s_prdata = {$urandom, $urandom};
    xfer(21'h180004, 1'b0, 16'h0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      slv_enable = 4'($urandom);
      s_prdata   = {$urandom, $urandom};
      s_pslverr  = 4'($urandom);
      xfer(21'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 5), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("mq_drained", 32'(mq.size()), 32'h0);
    check("sq_drained", 32'(sq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_apb_fabric.md
Name: mdio_apb_fabric

Overview:
- Downstream of the MDIO slave's APB request port: one APB3 master (21-bit address, 16-bit data) fanned out to NSLV register-bank slaves, decoded on the top address bits.
- Registers the full transaction, so slave combinational paths never reach the MDIO side.
- Slaves that never respond get a watchdog timeout; unmapped accesses return PSLVERR.
- Sits in the 100 MHz control domain.

Parameters:
- NSLV, 4, number of slave ports (power of 2, 2..8)
- SEL_LSB, 19, LSB of the slave-index field; index = m_paddr[SEL_LSB+log2(NSLV)-1:SEL_LSB]
- TIMEOUT, 255, access-phase cycles before abort; 0 disables the watchdog
- ERR_DATA, 16'hDEAD, m_prdata returned on unmapped or timed-out reads

Ports:
- clk_100m  in  1  clock
- rstn_100m  in  1  asynchronous active-low reset
- m_paddr  in  21  master address
- m_pwrite / m_psel / m_penable  in  1 each  master APB controls
- m_pwdata  in  16  master write data
- m_pready / m_pslverr  out  1 each  master response
- m_prdata  out  16  master read data
- s_paddr  out  21  shared slave address (registered)
- s_pwrite / s_penable  out  1 each  shared slave controls
- s_pwdata  out  16  shared slave write data
- s_psel  out  NSLV  one-hot slave select
- s_pready / s_pslverr  in  NSLV each  per-slave response
- s_prdata  in  16*NSLV  slave i occupies bits [16i+15:16i]
- slv_enable  in  NSLV  static map; 0 = unmapped
- err_timeout / err_unmapped  out  1 each  one-cycle status pulses
- timeout_cnt  out  8  saturating count of timeouts; clears only on reset

Behaviour:
- Reset: every output is 0 and the FSM is IDLE. Reset mid-transaction aborts silently with no response.
- Clock/reset: one clock, clk_100m; reset rstn_100m is asynchronous and active-low.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On m_psel=1 & m_penable=0, capture addr/write/wdata and the slave index.
  - If slv_enable[idx]=0: go to DONE with slverr=1, rdata=ERR_DATA (0 on writes), and pulse err_unmapped. No slave is selected.
  - Otherwise go to SETUP.
- SETUP (one cycle): s_psel[idx]=1, s_penable=0, s_paddr/s_pwrite/s_pwdata come from the capture registers.
- ACCESS:
  - s_psel[idx]=1, s_penable=1; the watchdog counter increments each cycle.
  - s_pready[idx]=1: capture s_prdata[idx] (0 on writes) and s_pslverr[idx], then go to DONE.
  - Counter reaches TIMEOUT with no pready: drop s_psel/s_penable, then go to DONE with slverr=1, rdata=ERR_DATA; pulse err_timeout; timeout_cnt increments (saturates at 255).
  - If pready and timeout occur in the same cycle, pready wins.
- DONE (one cycle): m_pready=1 with registered m_prdata/m_pslverr, then IDLE. m_prdata and m_pslverr are 0 whenever m_pready=0.
- Latency: a zero-wait slave completes with m_pready high 3 cycles after the master setup cycle (setup T0, SETUP T1, ACCESS T2, DONE T3). Each slave wait state adds one cycle.
- Master drops m_psel during SETUP/ACCESS: the slave access still completes (APB cannot abort), but DONE is suppressed (m_pready stays 0) and the FSM returns to IDLE.
- Back-to-back: a new setup is only accepted in IDLE. Requests arriving during DONE are taken on the following IDLE cycle.
- Buses s_paddr/s_pwdata/s_pwrite hold their values outside transfers. Only s_psel/s_penable return to 0.
- Watchdog counter width is clog2(TIMEOUT+1). It clears on entry to SETUP.

Decomposition:
- Shared package mdio_apb_pkg holds:
  - APB_AW=21, APB_DW=16
  - FSM state enum
  - ERR_DATA default
  - the slave-index width function
- Optional sub-module mdio_apb_wdog: watchdog counter plus saturating timeout_cnt. Everything else stays flat.

Test Plan:
- Write 16'h1234 to addr 21'h080010 (slave 1, zero wait) -> s_psel=4'b0010 at T1, s_penable at T2, m_pready=1 at T3, m_pslverr=0.
- Read slave 2 inserting 3 wait states with s_prdata=16'hBEEF -> m_pready at T6, m_prdata=16'hBEEF, then m_prdata=0 the next cycle.
- slv_enable=4'b0111, read addr 21'h180000 -> no s_psel, err_unmapped pulses, m_pready at T1 with m_pslverr=1 and m_prdata=16'hDEAD.
- TIMEOUT=4, slave 0 never ready -> s_psel drops after 4 ACCESS cycles, err_timeout pulses, m_pslverr=1, timeout_cnt=1. Repeat 300x -> timeout_cnt saturates at 8'hFF.
- Master deasserts m_psel in the second ACCESS cycle, slave readies in the third -> slave transfer completes, m_pready never asserts, next request serviced normally.
- Assert rstn_100m low during ACCESS -> all outputs 0 asynchronously. After release, a zero-wait read of slave 3 completes at T3.
